// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encoding and BCD limits for the microwave countdown timer
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one decade of the BCD down-counter with wrap and borrow
module bcd_down_digit
    import microwave_pkg::*;
#(
    parameter logic [3:0] WRAP = BCD_MAX
) (
    input  logic [3:0] digit,
    input  logic       dec_en,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (dec_en) begin
            if (digit == 4'd0) begin
                next_digit = WRAP;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// rtl/microwave_timer.sv - keypad-loaded three-digit BCD countdown timer with pause and done pulse
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       running,
    output logic       zero,
    output logic       done
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    timer_state_t  state;
    logic [PW-1:0] presc;

    logic [3:0] ones_nxt, tens_nxt, mins_nxt;
    logic       ones_borrow, tens_borrow, mins_borrow;
    logic       tick;
    logic       next_zero;

    assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

    bcd_down_digit #(.WRAP(BCD_MAX)) u_ones (
        .digit      (sec_ones),
        .dec_en     (tick),
        .next_digit (ones_nxt),
        .borrow_out (ones_borrow)
    );

    bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_tens (
        .digit      (sec_tens),
        .dec_en     (ones_borrow),
        .next_digit (tens_nxt),
        .borrow_out (tens_borrow)
    );

    bcd_down_digit #(.WRAP(BCD_MAX)) u_mins (
        .digit      (mins),
        .dec_en     (tens_borrow),
        .next_digit (mins_nxt),
        .borrow_out (mins_borrow)
    );

    assign zero      = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (mins == 4'd0);
    assign next_zero = (ones_nxt == 4'd0) && (tens_nxt == 4'd0) && (mins_nxt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            presc    <= '0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            mins     <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state    <= ST_IDLE;
                presc    <= '0;
                sec_ones <= 4'd0;
                sec_tens <= 4'd0;
                mins     <= 4'd0;
                running  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pause) begin
                            state <= ST_IDLE;
                        end else if (start) begin
                            if (!zero) begin
                                state   <= ST_RUN;
                                running <= 1'b1;
                                presc   <= '0;
                            end
                        end else if (key_valid && is_bcd(key_digit)) begin
                            mins     <= sec_tens;
                            sec_tens <= sec_ones;
                            sec_ones <= key_digit;
                        end
                    end
                    ST_RUN: begin
                        // pause outranks a coincident tick: digits and prescaler both hold
                        if (pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            presc <= '0;
                            // a borrow out of minutes would mean counting below 0:00; park at zero instead
                            if (next_zero || mins_borrow) begin
                                sec_ones <= 4'd0;
                                sec_tens <= 4'd0;
                                mins     <= 4'd0;
                                state    <= ST_DONE;
                                running  <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                sec_ones <= ones_nxt;
                                sec_tens <= tens_nxt;
                                mins     <= mins_nxt;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause && start) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_DONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
// tb/tb_microwave_timer.sv - randomized and directed bench for microwave_timer against a digit-level model
module tb_microwave_timer;

    localparam int TD = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, mins;
    logic       running, zero, done;

    always #5 clk = ~clk;

    microwave_timer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .mins      (mins),
        .running   (running),
        .zero      (zero),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;

    int m_st;
    int m_ones, m_tens, m_mins;
    int m_left;
    bit m_done;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_ones = 0;
        m_tens = 0;
        m_mins = 0;
        m_left = TD;
        m_done = 0;
    endtask

    function automatic bit model_is_zero();
        return (m_ones == 0) && (m_tens == 0) && (m_mins == 0);
    endfunction

    task automatic model_edge(input bit kv, input int kd, input bit st, input bit pa, input bit cl);
        m_done = 0;
        if (cl) begin
            m_st = M_IDLE;
            m_ones = 0; m_tens = 0; m_mins = 0;
        end else if (m_st == M_RUN) begin
            if (pa) begin
                m_st = M_PAUSE;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_left = TD;
                    if (m_ones > 0) m_ones--;
                    else begin
                        m_ones = 9;
                        if (m_tens > 0) m_tens--;
                        else begin
                            m_tens = 5;
                            m_mins--;
                        end
                    end
                    if (model_is_zero()) begin
                        m_st = M_DONE;
                        m_done = 1;
                    end
                end
            end
        end else if (m_st == M_PAUSE) begin
            if (!pa && st) m_st = M_RUN;
        end else if (m_st == M_IDLE) begin
            if (pa) begin
                m_st = M_IDLE;
            end else if (st) begin
                if (!model_is_zero()) begin
                    m_st = M_RUN;
                    m_left = TD;
                end
            end else if (kv && kd <= 9) begin
                m_mins = m_tens;
                m_tens = m_ones;
                m_ones = kd;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, " digits"}, {20'd0, mins, sec_tens, sec_ones}, 32'(m_mins * 256 + m_tens * 16 + m_ones));
        check_eq({tag, " running"}, {31'd0, running}, {31'd0, (m_st == M_RUN)});
        check_eq({tag, " zero"}, {31'd0, zero}, {31'd0, model_is_zero()});
        check_eq({tag, " done"}, {31'd0, done}, {31'd0, m_done});
    endtask

    // called at a falling edge; leaves the bench at the next falling edge
    task automatic cycle(input bit kv, input int kd, input bit st, input bit pa, input bit cl, input string tag);
        key_valid = kv;
        key_digit = kd[3:0];
        start     = st;
        pause     = pa;
        clear     = cl;
        @(posedge clk);
        model_edge(kv, kd, st, pa, cl);
        @(negedge clk);
        key_valid = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        clear     = 1'b0;
        check_outputs(tag);
    endtask

    task automatic nop(input string tag);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic key(input int d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0, "key");
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check_eq("reset zero const", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;
        nop("post reset");

        key(1); key(3); key(0); key(7);
        check_eq("keys 3:07", {20'd0, mins, sec_tens, sec_ones}, 32'h307);
        key(12);
        check_eq("key 12 ignored", {20'd0, mins, sec_tens, sec_ones}, 32'h307);

        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, "clear");
        key(1); key(0); key(0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, "start 1:00");
        check_eq("running after start", {31'd0, running}, 32'd1);
        for (int i = 0; i < 3; i++) nop("run 1:00");
        nop("run 1:00 tick");
        check_eq("1:00 -> 0:59", {20'd0, mins, sec_tens, sec_ones}, 32'h059);
        for (int i = 0; i < 4; i++) nop("run 0:59");
        check_eq("0:59 -> 0:58", {20'd0, mins, sec_tens, sec_ones}, 32'h058);

        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, "clear");
        key(2);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, "start 0:02");
        for (int i = 0; i < 4; i++) nop("run 0:02");
        check_eq("0:02 -> 0:01", {20'd0, mins, sec_tens, sec_ones}, 32'h001);
        for (int i = 0; i < 4; i++) nop("run 0:01");
        check_eq("done pulse", {31'd0, done}, 32'd1);
        check_eq("done zero", {31'd0, zero}, 32'd1);
        check_eq("done not running", {31'd0, running}, 32'd0);
        nop("after done");
        check_eq("done single cycle", {31'd0, done}, 32'd0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, "start in DONE");
        check_eq("start ignored in DONE", {31'd0, running}, 32'd0);

        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, "clear");
        key(7); key(5);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, "start 0:75");
        for (int i = 0; i < 4; i++) nop("run 0:75");
        check_eq("0:75 -> 0:74", {20'd0, mins, sec_tens, sec_ones}, 32'h074);
        nop("run 0:74");
        nop("run 0:74");
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, "pause");
        for (int i = 0; i < 20; i++) nop("paused");
        check_eq("paused hold", {20'd0, mins, sec_tens, sec_ones}, 32'h074);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, "resume");
        nop("resumed");
        check_eq("resume +1 holds", {20'd0, mins, sec_tens, sec_ones}, 32'h074);
        nop("resumed");
        check_eq("resume +2 0:73", {20'd0, mins, sec_tens, sec_ones}, 32'h073);

        cycle(1'b0, 0, 1'b1, 1'b1, 1'b0, "pause+start");
        check_eq("pause beats start", {31'd0, running}, 32'd0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b1, "clear+start");
        check_eq("clear beats start", {20'd0, mins, sec_tens, sec_ones, running}, 32'd0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, "start at 0:00");
        check_eq("start at zero ignored", {31'd0, running}, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, "rnd clear");
            else if (r < 6)  cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, "rnd pause");
            else if (r < 14) cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, "rnd start");
            else if (r < 34) cycle(1'b1, int'($urandom_range(0, 11)), 1'b0, 1'b0, 1'b0, "rnd key");
            else             nop("rnd idle");
        end

        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, "clear");
        key(2); key(4); key(1);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, "start 2:41");
        nop("run 2:41");
        rst_n = 1'b0;
        #1;
        check_eq("async reset digits", {20'd0, mins, sec_tens, sec_ones}, 32'd0);
        check_eq("async reset running", {31'd0, running}, 32'd0);
        check_eq("async reset zero", {31'd0, zero}, 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        nop("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
# microwave_timer

Countdown timer that produces the three BCD digits (minutes, tens of seconds, units of seconds) consumed by the 7-segment display decoder. Keypad digits shift in from the right while idle. A start pulse counts the value down once per prescaled tick to 0:00, then signals completion. It sits between the keypad encoder/control logic and the display decoder, which is purely combinational on these outputs.

## Interface
- `TICK_DIV`, default 100: clock cycles per one-second decrement; must be ≥ 2.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `key_valid` input, 1 bit: one-cycle pulse; `key_digit` is valid.
- `key_digit` input, 4 bits: keypad digit, 0–9.
- `start` input, 1 bit: one-cycle pulse; begin or resume the countdown.
- `pause` input, 1 bit: one-cycle pulse; suspend the countdown.
- `clear` input, 1 bit: one-cycle pulse; abort and zero the timer.
- `sec_ones` output, 4 bits: units-of-seconds BCD digit, registered.
- `sec_tens` output, 4 bits: tens-of-seconds BCD digit, registered.
- `mins` output, 4 bits: minutes BCD digit, registered.
- `running` output, 1 bit: high in RUN.
- `zero` output, 1 bit: all three digits equal 0.
- `done` output, 1 bit: one-cycle pulse when the countdown reaches 0:00.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- Reset values: all digits 0, `running`=0, `done`=0, `zero`=1, prescaler 0.
- Input priority within one cycle: `clear` > `pause` > `start` > `key_valid`.
- `clear` in any state: go to IDLE, zero all digits, zero the prescaler, no `done` pulse.
- IDLE, `key_valid` with `key_digit` ≤ 9: shift left. `mins`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`key_digit`. The old `mins` value is discarded.
- `key_digit` > 9: ignored, no change.
- `key_valid` in RUN, PAUSE or DONE: ignored.
- IDLE, `start` with a nonzero value: go to RUN and zero the prescaler.
- IDLE, `start` with value 0:00: ignored, stay in IDLE.
- RUN: the prescaler counts 0..`TICK_DIV`−1. At `TICK_DIV`−1 the prescaler wraps to 0 and the value decrements by one second.
- RUN, `pause`: go to PAUSE. Digits hold; the prescaler holds its current count.
- PAUSE, `start`: go to RUN. The prescaler continues from its held count.
- PAUSE, `pause`: no effect.
- Decrement rule (borrow chain):
  - `sec_ones` 0→9 and borrows from `sec_tens`; otherwise `sec_ones`−1.
  - `sec_tens` 0→5 and borrows from `mins`; otherwise `sec_tens`−1.
  - `mins` decrements only on a borrow.
- Entered `sec_tens` values 6–9 are legal. They count down normally, so 0:75 counts 75 seconds.
- Decrement that produces 0:00: go to DONE and pulse `done` in the same cycle the digits become 0.
- DONE: digits stay 0. `start`, `pause` and keys are ignored. Only `clear` exits.
- `pause` and a tick in the same cycle: `pause` wins and the decrement does not occur.

## Timing
- Key pulse at edge k: digits are updated after edge k.
- `start` at edge s: `running`=1 after edge s. First decrement at edge s+`TICK_DIV`, then every `TICK_DIV` cycles.
- `done` is high for exactly one cycle. It is aligned with the first cycle of `zero`=1 and `running`=0.
- `zero` is combinational from the digit registers. All other outputs are registered.
- Reset asserted mid-count: all outputs return to reset values immediately (asynchronous). Operation resumes in IDLE on the first edge after deassertion.
- Prescaler width is $clog2(`TICK_DIV`).

## Structure
- Shared package `microwave_pkg` holds:
  - the state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3);
  - `BCD_MAX`=9;
  - `SEC_TENS_MAX`=5.
- Sub-module `bcd_down_digit`:
  - inputs: one decade's value, `dec_en`, and a wrap value parameter (9 or 5);
  - outputs: the next value and a `borrow_out`.
  - Instantiate it three times as a chain; `mins` wraps at 9, but that wrap is unreachable because zero detection intervenes.

## Test plan
Run all scenarios with `TICK_DIV`=4.
- Keys 1, 3, 0 then 7 → digits 3:07, and the first key is discarded. Then `key_digit`=12 → still 3:07.
- Value 1:00, `start` → `running` after 1 cycle. After 4 cycles 0:59; after 8 cycles 0:58.
- Value 0:02, `start` → 0:01 at +4, then 0:00 with a single-cycle `done` at +8, then DONE. A further `start` is ignored.
- Value 0:75, `start` → 0:74 at +4. Pause at +6, wait 20 cycles (value holds), `start` → 0:73 exactly 2 cycles later.
- `pause` and `start` pulsed together in RUN → PAUSE. `clear` and `start` together → IDLE at 0:00. `start` at 0:00 → stays IDLE.
- `rst_n` low mid-count at 2:41 → outputs 0:00, `running`=0 asynchronously, before the next edge.
